// File: rtl/alu_issue_pkg.sv
// Shared encodings for the ALU issue stage: RV32I opcodes, ALU control codes, branch funct3.
// Unsigned branches (bltu/bgeu) are only decoded when ALU_ISSUE_UNSIGNED_BR_EN is defined.
package alu_issue_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of opcode/funct fields into ALU control, operand-B select and flags.
// Honours ALU_ISSUE_UNSIGNED_BR_EN for the bltu/bgeu encodings.
module alu_ctrl_decode
  import alu_issue_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_ctrl,
  output logic       b_sel_imm,
  output logic       is_branch,
  output logic       illegal
);

  always_comb begin
    alu_ctrl  = ALU_ADD;
    b_sel_imm = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_R, OP_I: begin
        b_sel_imm = (opcode == OP_I);
        case (funct3)
          3'b000:  alu_ctrl = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: illegal  = 1'b1;
        endcase
      end
      OP_LOAD, OP_STORE: b_sel_imm = 1'b1;
      OP_BRANCH: begin
        alu_ctrl  = ALU_SUB;
        is_branch = 1'b1;
        case (funct3)
          F3_BEQ, F3_BNE, F3_BLT, F3_BGE: illegal = 1'b0;
`ifdef ALU_ISSUE_UNSIGNED_BR_EN
          F3_BLTU, F3_BGEU:               illegal = 1'b0;
`endif
          default:                        illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    // Illegal encodings present a neutral add of zeros to the ALU
    if (illegal) begin
      alu_ctrl  = ALU_ADD;
      b_sel_imm = 1'b0;
      is_branch = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage ALU front end: stage 1 registers ALU operands, stage 2 captures result and branch outcome.
// Define ALU_ISSUE_UNSIGNED_BR_EN to enable bltu/bgeu; otherwise they are flagged illegal.
module alu_issue_stage
  import alu_issue_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_z,
  input  logic            alu_n,
  input  logic            alu_c,
  input  logic            alu_v,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_taken,
  output logic            out_illegal
);

  logic [2:0] dec_ctrl;
  logic       dec_b_imm;
  logic       dec_branch;
  logic       dec_illegal;

  logic       s1_valid;
  logic [2:0] s1_funct3;
  logic       s1_is_branch;
  logic       s1_illegal;
  logic       s2_valid;
  logic       s1_advance;
  logic       accept;
  logic       taken;

  alu_ctrl_decode u_decode (
    .opcode    (in_opcode),
    .funct3    (in_funct3),
    .funct7b5  (in_funct7b5),
    .alu_ctrl  (dec_ctrl),
    .b_sel_imm (dec_b_imm),
    .is_branch (dec_branch),
    .illegal   (dec_illegal)
  );

  assign s1_advance = s1_valid & (~s2_valid | out_ready);
  assign in_ready   = ~s1_valid | s1_advance;
  assign accept     = in_valid & in_ready;
  assign out_valid  = s2_valid;

  // Branch outcome from the flags of the rs1 - rs2 subtraction
  always_comb begin
    taken = 1'b0;
    if (s1_is_branch) begin
      case (s1_funct3)
        F3_BEQ:  taken = alu_z;
        F3_BNE:  taken = ~alu_z;
        F3_BLT:  taken = alu_n ^ alu_v;
        F3_BGE:  taken = ~(alu_n ^ alu_v);
`ifdef ALU_ISSUE_UNSIGNED_BR_EN
        F3_BLTU: taken = ~alu_c;
        F3_BGEU: taken = alu_c;
`endif
        default: taken = 1'b0;
      endcase
    end
  end

`ifndef ALU_ISSUE_UNSIGNED_BR_EN
  logic carry_unused;
  assign carry_unused = alu_c;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid     <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_ctrl     <= ALU_ADD;
      s1_funct3    <= 3'b000;
      s1_is_branch <= 1'b0;
      s1_illegal   <= 1'b0;
    end else if (accept) begin
      s1_valid     <= 1'b1;
      alu_a        <= dec_illegal ? '0 : in_rs1;
      alu_b        <= dec_illegal ? '0 : (dec_b_imm ? in_imm : in_rs2);
      alu_ctrl     <= dec_ctrl;
      s1_funct3    <= in_funct3;
      s1_is_branch <= dec_branch;
      s1_illegal   <= dec_illegal;
    end else if (s1_advance) begin
      s1_valid     <= 1'b0;
    end
  end

  // Stage 2 reloads on the same edge it drains, so out_valid stays high at full rate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid    <= 1'b0;
      out_result  <= '0;
      out_taken   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (s1_advance) begin
      s2_valid    <= 1'b1;
      out_result  <= s1_illegal ? '0 : alu_result;
      out_taken   <= taken;
      out_illegal <= s1_illegal;
    end else if (out_ready) begin
      s2_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage with a behavioural ALU and an instruction-level reference model.
// Expectations for bltu/bgeu follow ALU_ISSUE_UNSIGNED_BR_EN.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_rs1, in_rs2, in_imm;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_z, alu_n, alu_c, alu_v;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_taken;
  logic        out_illegal;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_funct3   (in_funct3),
    .in_funct7b5 (in_funct7b5),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .alu_z       (alu_z),
    .alu_n       (alu_n),
    .alu_c       (alu_c),
    .alu_v       (alu_v),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_taken   (out_taken),
    .out_illegal (out_illegal)
  );

  // Behavioural ALU sitting at the parent level, returning result and flags combinationally
  logic [31:0] alu_opb;
  logic [32:0] alu_sum;
  assign alu_opb = (alu_ctrl == 3'b001) ? ~alu_b : alu_b;
  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_opb} + ((alu_ctrl == 3'b001) ? 33'd1 : 33'd0);

  always_comb begin
    alu_result = 32'd0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    case (alu_ctrl)
      3'b000, 3'b001: begin
        alu_result = alu_sum[31:0];
        alu_c      = alu_sum[32];
        alu_v      = (alu_a[31] == alu_opb[31]) && (alu_sum[31] != alu_a[31]);
      end
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b101:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = 32'd0;
    endcase
    alu_z = (alu_result == 32'd0);
    alu_n = alu_result[31];
  end

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] result;
    logic        taken;
    logic        illegal;
  } exp_t;

  exp_t exp_q[$];

  // Instruction-level reference: what the ALU should see and what the stage should report
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    exp_t e;
    logic [31:0] b;
    logic ok;
    e  = '0;
    ok = 1'b1;
    case (op)
      7'b0110011, 7'b0010011: begin
        b = (op == 7'b0110011) ? rs2 : imm;
        e.a = rs1;
        e.b = b;
        case (f3)
          3'b000: begin
            if (op == 7'b0110011 && f7) begin e.ctrl = 3'b001; e.result = rs1 - b; end
            else                        begin e.ctrl = 3'b000; e.result = rs1 + b; end
          end
          3'b010:  begin e.ctrl = 3'b101; e.result = ($signed(rs1) < $signed(b)) ? 32'd1 : 32'd0; end
          3'b110:  begin e.ctrl = 3'b011; e.result = rs1 | b; end
          3'b111:  begin e.ctrl = 3'b010; e.result = rs1 & b; end
          default: ok = 1'b0;
        endcase
      end
      7'b0000011, 7'b0100011: begin
        e.a = rs1; e.b = imm; e.ctrl = 3'b000; e.result = rs1 + imm;
      end
      7'b1100011: begin
        e.a = rs1; e.b = rs2; e.ctrl = 3'b001; e.result = rs1 - rs2;
        case (f3)
          3'b000:  e.taken = (rs1 == rs2);
          3'b001:  e.taken = (rs1 != rs2);
          3'b100:  e.taken = ($signed(rs1) < $signed(rs2));
          3'b101:  e.taken = ($signed(rs1) >= $signed(rs2));
`ifdef ALU_ISSUE_UNSIGNED_BR_EN
          3'b110:  e.taken = (rs1 < rs2);
          3'b111:  e.taken = (rs1 >= rs2);
`endif
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = '0;
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  exp_t        alu_pend;
  logic        alu_pend_v  = 1'b0;
  logic        stall_pend_v = 1'b0;
  logic [31:0] stall_res;
  logic        stall_tk, stall_il;
  logic        hold_pend_v = 1'b0;
  logic [31:0] hold_a, hold_b;
  logic [2:0]  hold_ctrl;

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      exp_q.delete();
      alu_pend_v   = 1'b0;
      stall_pend_v = 1'b0;
      hold_pend_v  = 1'b0;
    end else begin
      if (alu_pend_v) begin
        checkOutput("alu_a", alu_a, alu_pend.a);
        checkOutput("alu_b", alu_b, alu_pend.b);
        checkOutput("alu_ctrl", 32'(alu_ctrl), 32'(alu_pend.ctrl));
        alu_pend_v = 1'b0;
      end
      if (hold_pend_v) begin
        checkOutput("hold_alu_a", alu_a, hold_a);
        checkOutput("hold_alu_b", alu_b, hold_b);
        checkOutput("hold_alu_ctrl", 32'(alu_ctrl), 32'(hold_ctrl));
        hold_pend_v = 1'b0;
      end
      if (stall_pend_v) begin
        checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_out_result", out_result, stall_res);
        checkOutput("stall_out_taken", 32'(out_taken), 32'(stall_tk));
        checkOutput("stall_out_illegal", 32'(out_illegal), 32'(stall_il));
        stall_pend_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_output", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_result", out_result, e.result);
          checkOutput("out_taken", 32'(out_taken), 32'(e.taken));
          checkOutput("out_illegal", 32'(out_illegal), 32'(e.illegal));
        end
      end
      if (out_valid && !out_ready) begin
        stall_pend_v = 1'b1;
        stall_res    = out_result;
        stall_tk     = out_taken;
        stall_il     = out_illegal;
      end
      if (!in_ready) begin
        hold_pend_v = 1'b1;
        hold_a      = alu_a;
        hold_b      = alu_b;
        hold_ctrl   = alu_ctrl;
      end
      if (in_valid && in_ready) begin
        e = model(in_opcode, in_funct3, in_funct7b5, in_rs1, in_rs2, in_imm);
        exp_q.push_back(e);
        alu_pend   = e;
        alu_pend_v = 1'b1;
      end
    end
  end

  // Presents one instruction and returns just after the edge that accepts it
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                               input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    logic done;
    done        = 1'b0;
    in_opcode   = op;
    in_funct3   = f3;
    in_funct7b5 = f7;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_imm      = imm;
    in_valid    = 1'b1;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    checkOutput("accept_in_time", 32'(done), 32'd1);
  endtask

  task automatic runDirected(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [2:0] exp_ctrl, input logic [31:0] exp_res,
                             input logic exp_tk, input logic exp_il);
    applyStimulus(op, f3, f7, rs1, rs2, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_ctrl"}, 32'(alu_ctrl), 32'(exp_ctrl));
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_result"}, out_result, exp_res);
    checkOutput({tag, "_taken"}, 32'(out_taken), 32'(exp_tk));
    checkOutput({tag, "_illegal"}, 32'(out_illegal), 32'(exp_il));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 64 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic applyRandom();
    logic [6:0]  op;
    logic [31:0] rs1, rs2;
    int          sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 2: op = 7'b0110011;
      3, 4:    op = 7'b0010011;
      5:       op = 7'b0000011;
      6:       op = 7'b0100011;
      7, 8:    op = 7'b1100011;
      default: op = 7'($urandom);
    endcase
    rs1 = $urandom;
    case ($urandom_range(0, 3))
      0:       rs2 = rs1;
      1:       rs2 = 32'($urandom_range(0, 15));
      default: rs2 = $urandom;
    endcase
    applyStimulus(op, 3'($urandom), 1'($urandom), rs1, rs2, $urandom);
    if ($urandom_range(0, 4) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic rand_done;

  initial begin
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    in_opcode   = 7'd0;
    in_funct3   = 3'd0;
    in_funct7b5 = 1'b0;
    in_rs1      = 32'd0;
    in_rs2      = 32'd0;
    in_imm      = 32'd0;
    rand_done   = 1'b0;

    #2 rst = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_alu_b", alu_b, 32'd0);
    checkOutput("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    checkOutput("rst_out_result", out_result, 32'd0);
    checkOutput("rst_out_taken", 32'(out_taken), 32'd0);
    checkOutput("rst_out_illegal", 32'(out_illegal), 32'd0);
    #9 rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed operations");
    runDirected("add", 7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 3'b000, 32'd12, 1'b0, 1'b0);
    runDirected("sub", 7'b0110011, 3'b000, 1'b1, 32'd3, 32'd5, 3'b001, 32'hFFFF_FFFE, 1'b0, 1'b0);
    runDirected("beq", 7'b1100011, 3'b000, 1'b0, 32'd9, 32'd9, 3'b001, 32'd0, 1'b1, 1'b0);
    runDirected("bne", 7'b1100011, 3'b001, 1'b0, 32'd9, 32'd9, 3'b001, 32'd0, 1'b0, 1'b0);
    runDirected("blt", 7'b1100011, 3'b100, 1'b0, 32'd2, 32'd5, 3'b001, 32'hFFFF_FFFD, 1'b1, 1'b0);
    runDirected("bad_opcode", 7'h7F, 3'b000, 1'b0, 32'd11, 32'd4, 3'b000, 32'd0, 1'b0, 1'b1);
`ifdef ALU_ISSUE_UNSIGNED_BR_EN
    runDirected("bltu", 7'b1100011, 3'b110, 1'b0, 32'd1, 32'd2, 3'b001, 32'hFFFF_FFFF, 1'b1, 1'b0);
`else
    runDirected("bltu", 7'b1100011, 3'b110, 1'b0, 32'd1, 32'd2, 3'b000, 32'd0, 1'b0, 1'b1);
`endif

    $display("[TB] back-to-back with downstream stall");
    fork
      begin
        applyStimulus(7'b0110011, 3'b110, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'd0);
        applyStimulus(7'b0010011, 3'b000, 1'b0, 32'd100, 32'd0, 32'hFFFF_FFFF);
        applyStimulus(7'b0000011, 3'b010, 1'b0, 32'h1000, 32'd0, 32'd8);
        applyStimulus(7'b1100011, 3'b101, 1'b0, 32'd7, 32'd7, 32'd0);
      end
      begin
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checkOutput("stall_in_ready_low", 32'(in_ready), 32'd0);
        checkOutput("stall_out_valid_high", 32'(out_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] randomized traffic");
    fork
      begin
        for (int i = 0; i < 400; i++) applyRandom();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("[TB] reset with both stages full");
    out_ready = 1'b0;
    applyStimulus(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0);
    applyStimulus(7'b0110011, 3'b111, 1'b0, 32'hFF, 32'h0F, 32'd0);
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    checkOutput("midrst_out_result", out_result, 32'd0);
    @(negedge clk);
    #3 rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("post_rst_idle", 32'(out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Pipelined front end that drives the 32-bit ALU with operands and a 3-bit ALU control code, then captures the returned result and Z/N/C/V flags. Decodes RV32I opcode/funct fields, selects register or immediate operand, registers them onto the ALU inputs, then resolves branch conditions from the flags. Sits between register-file read and writeback/PC-select, with valid/ready handshakes on both sides.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  block accepts this cycle.
- in_opcode  in  7  instr[6:0].
- in_funct3  in  3  instr[14:12].
- in_funct7b5  in  1  instr[30].
- in_rs1, in_rs2, in_imm  in  32 each  register operands, sign-extended immediate.
- alu_a, alu_b  out  32 each  registered ALU operands.
- alu_ctrl  out  3  registered code: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- alu_result  in  32  ALU result (combinational return).
- alu_z, alu_n, alu_c, alu_v  in  1 each  ALU flags.
- out_valid  out  1  stage-2 holds a result.
- out_ready  in  1  downstream accepts.
- out_result  out  32  captured result.
- out_taken  out  1  branch condition true (0 for non-branches).
- out_illegal  out  1  unsupported encoding.

## Operation
- R-type (0110011): funct3 000 → add, or sub if funct7b5; 010 → slt; 110 → or; 111 → and; B=rs2. Other funct3 illegal.
- I-type ALU (0010011): as R-type, funct3 000 always add; B=imm.
- Load (0000011), store (0100011): add, B=imm.
- Branch (1100011): sub, B=rs2. funct3 000 beq: taken=Z; 001 bne: ~Z; 100 blt: N^V; 101 bge: ~(N^V); 110 bltu: ~C; 111 bgeu: C. 010/011 illegal.
- Any other opcode: illegal; alu_a=alu_b=0, alu_ctrl=000, out_result=0, out_taken=0, out_illegal=1.
- Stage 1 (s1_valid): register decoded alu_a/alu_b/alu_ctrl plus branch funct3, is_branch, illegal flags.
- Stage 2 (s2_valid): on s1→s2 transfer, capture alu_result and compute out_taken from flags and stored funct3.
- out_valid = s2_valid. s2 frees when out_ready. s1 advances when ~s2_valid | out_ready. in_ready = ~s1_valid | s1_advance (combinational, no skid buffer).
- Throughput one instruction/cycle with out_ready held high.

## Timing
- Reset: s1_valid=s2_valid=0; alu_a=alu_b=0; alu_ctrl=000; out_result=0; out_taken=0; out_illegal=0; in_ready=1 while rst low.
- Accept at edge k → ALU inputs valid after k → out_valid high after k+1 (one-cycle ALU window).
- Stalls (s2 full, out_ready=0): alu_a/alu_b/alu_ctrl and all out_* held stable; in_ready=0 if s1 full.
- Simultaneous out_ready=1 and s1 full: s2 reloads same edge, out_valid stays high; in_ready=1 that cycle.
- Reset mid-operation: in-flight entries discarded, no partial output.

## Configuration
- ALU_ISSUE_UNSIGNED_BR_EN defined: bltu/bgeu decoded as above.
- Not defined: funct3 110/111 branches flagged illegal (out_taken=0, out_illegal=1); carry input unused.

## Structure
- Package alu_issue_pkg: opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH), ALU control codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT), branch funct3 constants.
- Sub-module alu_ctrl_decode: combinational opcode/funct → alu_ctrl, b_sel_imm, is_branch, illegal. Top holds both pipeline stages and branch resolution. ALU instantiated outside, at the parent.

## Test plan
- R add rs1=5, rs2=7, out_ready=1 → alu_ctrl=000, alu_a=5, alu_b=7; given result 12, out_result=12 one cycle after ALU inputs present, out_taken=0.
- R sub (funct7b5=1) rs1=3, rs2=5 → alu_ctrl=001; flags N=1,Z=0 returned; out_result=0xFFFFFFFE.
- beq rs1=rs2=9 → alu_ctrl=001, Z=1 → out_taken=1; bne same operands → out_taken=0; blt with N=1,V=0 → out_taken=1.
- Back-to-back 4 instructions, out_ready=0 for 3 cycles mid-stream → in_ready drops after both stages fill, alu_* and out_* stable, all 4 emerge in order, no loss or duplication.
- Opcode 0x7F → out_illegal=1, out_result=0, alu_ctrl=000; bltu with macro off → out_illegal=1; with macro on, C=0 → out_taken=1.
- Drop rst low with both stages full → out_valid=0, in_ready=1, alu_ctrl=000 immediately; no output after release.
